// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_e;

   localparam int MULT_WIDTH_DEF = 32;

   // Iteration counter width; never narrower than one bit.
   function automatic int cnt_w(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/mult_seq_fa_nbit.sv
// WIDTH-bit ripple-carry adder, the only adder in the multiplier datapath.
module fa_nbit #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] Sum,
   output logic             cout,
   output logic             of
);

   logic [WIDTH:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign Sum[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
   end

   assign cout = c[WIDTH];
   // Signed overflow: carry into the sign bit differs from carry out.
   assign of   = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/mult_seq.sv
// Iterative unsigned shift-and-add multiplier, one partial product per cycle
// through a single ripple adder, with start/busy/done handshake.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [0:WIDTH-1]   a,
   input  logic [0:WIDTH-1]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               of
);

   localparam int CW = cnt_w(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_RUN  = 2'(RUN);
   localparam logic [1:0] ST_DONE = 2'(DONE);

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mq_q, mq_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               of_q, of_d;

   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;
   logic [2*WIDTH-1:0] shifted;

   assign add_b = mq_q[0] ? mcand_q : '0;

   fa_nbit #(.WIDTH(WIDTH)) u_add (
      .A    (acc_q),
      .B    (add_b),
      .cin  (1'b0),
      .Sum  (add_sum),
      .cout (add_cout),
      .of   ()
   );

   // {cout, Sum, mq} >> 1: carry becomes the new acc MSB, Sum LSB enters mq.
   assign shifted = {add_cout, add_sum, mq_q[WIDTH-1:1]};

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      count_d   = count_q;
      product_d = product_q;
      of_d      = of_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               mcand_d = a;
               mq_d    = b;
               acc_d   = '0;
               count_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d   = shifted[2*WIDTH-1:WIDTH];
            mq_d    = shifted[WIDTH-1:0];
            count_d = count_q + 1'b1;
            if (count_q == CNT_LAST) begin
               state_d   = ST_DONE;
               product_d = shifted;
               of_d      = |shifted[2*WIDTH-1:WIDTH];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         count_q   <= '0;
         product_q <= '0;
         of_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         count_q   <= count_d;
         product_q <= product_d;
         of_q      <= of_d;
      end
   end

   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign product = product_q;
   assign of      = of_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector bench for mult_seq at WIDTH=32.
module tb_mult_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [0:31] a;
   logic [0:31] b;
   logic        busy;
   logic        done;
   logic [63:0] product;
   logic        of;

   int n_vec = 0;
   int n_err = 0;

   mult_seq #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .of      (of)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Leaves the bench one negedge after the accepting edge.
   task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // n counts edges from the accepting edge; done is expected at n == 33.
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic [63:0] exp_p, input logic exp_of);
      int n;
      start_op(av, bv);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      wait_done(n);
      chk({tag, "_lat"}, 64'(n), 64'd33);
      chk({tag, "_prod"}, product, exp_p);
      chk({tag, "_of"}, 64'(of), 64'(exp_of));
      chk({tag, "_nobusy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      int dn;
      int dn_at;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_prod", product, 64'd0);
      chk("rst_of", 64'(of), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
      run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
      run("bnd_of", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
      run("bnd_fit", 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, 1'b0);
      run("zero", 32'd0, 32'hDEAD_BEEF, 64'd0, 1'b0);

      // start pulsed mid-RUN must be ignored.
      start_op(32'd100, 32'd200);
      dn    = 0;
      dn_at = 0;
      for (int i = 2; i <= 45; i++) begin
         @(negedge clk);
         if (i == 11) begin
            a     = 32'd5;
            b     = 32'd5;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            dn++;
            dn_at = i;
            chk("ign_prod", product, 64'd20000);
         end
         if (busy && done) chk("ign_excl", 64'd1, 64'd0);
      end
      chk("ign_ndone", 64'(dn), 64'd1);
      chk("ign_lat", 64'(dn_at), 64'd33);

      // Back-to-back: start held during the DONE cycle.
      start_op(32'h1234, 32'h10);
      wait_done(n);
      chk("b2b_first", product, 64'h12340);
      a     = 32'd7;
      b     = 32'd6;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_nodone", 64'(done), 64'd0);
      chk("b2b_hold", product, 64'h12340);
      wait_done(n);
      chk("b2b_lat", 64'(n), 64'd33);
      chk("b2b_prod", product, 64'd42);
      chk("b2b_of", 64'(of), 64'd0);

      // Asynchronous reset in the middle of an operation.
      start_op(32'd9, 32'd9);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_prod", product, 64'd0);
      chk("mrst_of", 64'(of), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("mrst_nodone", 64'(dn), 64'd0);
      run("post_rst", 32'd11, 32'd13, 64'd143, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
